win_check: RTL and testbench

WIN_CHECK -- requirements
Module: win_check

---
 rtl/win_check.sv | 85 ++++++++
 tb/tb_win_check.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/win_check.sv
// win_check: connect-four win scanner, one (cell,direction) pair per cycle; define WIN_CHECK_DRAW_EN to report full-board draws as winner=3
module win_check (
  input  logic        clk,
  input  logic        rst,
  input  logic [97:0] grid,
  output logic [1:0]  winner,
  output logic        win_valid,
  output logic        busy,
  output logic [2:0]  win_row,
  output logic [2:0]  win_col,
  output logic [1:0]  win_dir
);
  localparam logic IDLE = 1'b0;
  localparam logic SCAN = 1'b1;
  logic        state, state_n;
  logic [83:0] snap;
  logic [2:0]  r, c;
  logic [1:0]  d;
  logic [6:0]  base, step, i1, i2, i3;
  logic [1:0]  c0, c1, c2, c3;
  logic        on, hit, last, changed, full;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    changed = grid[83:0] != snap;
    last = r == 3'd5 && c == 3'd6 && d == 2'd3;
    state_n = state == IDLE ? (changed ? SCAN : IDLE) : (hit || last ? IDLE : SCAN);
  end
  assign busy = state == SCAN;
  // The line fits on the board iff its far end does; indices are zeroed otherwise to stay in range
  always_comb begin
    on = (d == 2'd0 || r <= 3'd2) && (d == 2'd1 || (d == 2'd3 ? c >= 3'd3 : c <= 3'd3));
    step = !on ? 7'd0 : d == 2'd0 ? 7'd126 : d == 2'd1 ? 7'd14 : d == 2'd2 ? 7'd12 : 7'd16;
    base = on ? 7'd14 * {4'd0, r} + 7'd12 - {3'd0, c, 1'b0} : 7'd0;
    i1 = base + step;
    i2 = i1 + step;
    i3 = i2 + step;
    c0 = snap[base +: 2];
    c1 = snap[i1 +: 2];
    c2 = snap[i2 +: 2];
    c3 = snap[i3 +: 2];
    hit = state == SCAN && on && (c0[1] ^ c0[0]) && c0 == c1 && c1 == c2 && c2 == c3;
  end
`ifdef WIN_CHECK_DRAW_EN
  always_comb begin
    full = 1'b1;
    for (int i = 0; i < 42; i++) full = full & (snap[2*i] ^ snap[2*i+1]);
  end
`else
  assign full = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      snap      <= '0;
      r         <= '0;
      c         <= '0;
      d         <= '0;
      winner    <= '0;
      win_valid <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
      win_dir   <= '0;
    end else begin
      win_valid <= 1'b0;
      if (state == IDLE) begin
        if (changed) begin
          snap <= grid[83:0];
          r    <= '0;
          c    <= '0;
          d    <= '0;
        end
      end else if (hit || last) begin
        winner    <= hit ? c0 : (full ? 2'd3 : 2'd0);
        win_row   <= hit ? r : 3'd0;
        win_col   <= hit ? c : 3'd0;
        win_dir   <= hit ? d : 2'd0;
        win_valid <= 1'b1;
      end else begin
        d <= d + 2'd1;
        c <= d == 2'd3 ? (c == 3'd6 ? 3'd0 : c + 3'd1) : c;
        r <= d == 2'd3 && c == 3'd6 ? r + 3'd1 : r;
      end
    end
endmodule

// File: tb/tb_win_check.sv
// tb_win_check: directed and random boards against a loop-over-lines reference model
module tb_win_check;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [97:0] grid = '0;
  logic [1:0]  winner;
  logic        win_valid;
  logic        busy;
  logic [2:0]  win_row;
  logic [2:0]  win_col;
  logic [1:0]  win_dir;
  int tests = 0;
  int fails = 0;
  logic [83:0] cur = '0;
  always #5 clk = ~clk;
  win_check dut (
    .clk(clk), .rst(rst), .grid(grid), .winner(winner), .win_valid(win_valid),
    .busy(busy), .win_row(win_row), .win_col(win_col), .win_dir(win_dir)
  );
  function automatic int cell_of(input logic [83:0] b, input int r, input int c);
    int sh;
    sh = 12 - 2*c + 14*r;
    return int'((b >> sh) & 84'd3);
  endfunction
  function automatic logic [83:0] set_cell(input logic [83:0] b, input int r, input int c, input int v);
    int sh;
    sh = 12 - 2*c + 14*r;
    return (b & ~(84'd3 << sh)) | (84'(v) << sh);
  endfunction
  function automatic void model(input logic [83:0] b, output int w, output int row, output int col,
                                output int dir, output int lat);
    int r, c, dr, dc, v, rr, cc, full;
    bit ok, found;
    w = 0; row = 0; col = 0; dir = 0; lat = 168; found = 0;
    for (int k = 0; k < 42; k++)
      for (int dd = 0; dd < 4; dd++) begin
        r = k / 7;
        c = k % 7;
        dr = (dd == 0) ? 0 : 1;
        dc = (dd == 1) ? 0 : (dd == 3) ? -1 : 1;
        v = cell_of(b, r, c);
        ok = (v == 1 || v == 2);
        for (int i = 1; i < 4; i++) begin
          rr = r + i*dr;
          cc = c + i*dc;
          if (rr > 5 || cc < 0 || cc > 6) ok = 0;
          else if (cell_of(b, rr, cc) != v) ok = 0;
        end
        if (ok && !found) begin
          found = 1; w = v; row = r; col = c; dir = dd; lat = 1 + 4*k + dd;
        end
      end
    full = 1;
    for (int r2 = 0; r2 < 6; r2++)
      for (int c2 = 0; c2 < 7; c2++)
        if (cell_of(b, r2, c2) == 0 || cell_of(b, r2, c2) == 3) full = 0;
`ifdef WIN_CHECK_DRAW_EN
    if (!found && full == 1) w = 3;
`endif
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic wait_result(input logic [83:0] b, input string tag, input int start);
    int w, row, col, dir, lat, cnt;
    model(b, w, row, col, dir, lat);
    cnt = start;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (!win_valid && cnt < 400);
    check({tag, ".lat"}, cnt, lat);
    check({tag, ".winner"}, {30'd0, winner}, w);
    check({tag, ".row"}, {29'd0, win_row}, row);
    check({tag, ".col"}, {29'd0, win_col}, col);
    check({tag, ".dir"}, {30'd0, win_dir}, dir);
  endtask
  task automatic drive_and_check(input logic [83:0] b, input string tag);
    @(negedge clk);
    grid = {14'($urandom), b};
    cur = b;
    @(posedge clk); #1;
    check({tag, ".busy"}, {31'd0, busy}, 1);
    wait_result(b, tag, 0);
    @(posedge clk); #1;
    check({tag, ".pulse"}, {31'd0, win_valid}, 0);
    check({tag, ".idle"}, {31'd0, busy}, 0);
  endtask
  initial begin
    logic [83:0] b, b2;
    int v;
    repeat (2) @(posedge clk);
    #1;
    check("reset.busy", {31'd0, busy}, 0);
    check("reset.valid", {31'd0, win_valid}, 0);
    check("reset.winner", {30'd0, winner}, 0);
    check("reset.anchor", {24'd0, win_row, win_col, win_dir}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("reset.noscan", {31'd0, busy}, 0);
    b = '0;
    for (int c = 0; c < 4; c++) b = set_cell(b, 0, c, 1);
    drive_and_check(b, "horiz");
    b = '0;
    for (int r = 0; r < 4; r++) b = set_cell(b, r, 6, 2);
    drive_and_check(b, "vert");
    b = '0;
    for (int i = 0; i < 4; i++) b = set_cell(b, i, 3 - i, 1);
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 3 - c; r++) b = set_cell(b, r, c, 2);
    drive_and_check(b, "diag");
    @(negedge clk);
    b = set_cell('0, 0, 6, 1);
    grid = {14'd0, b};
    cur = b;
    @(posedge clk); #1;
    check("rst.busy", {31'd0, busy}, 1);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst.busy0", {31'd0, busy}, 0);
    check("rst.valid0", {31'd0, win_valid}, 0);
    check("rst.winner0", {30'd0, winner}, 0);
    check("rst.anchor0", {24'd0, win_row, win_col, win_dir}, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst.nopulse", {31'd0, win_valid}, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst.rescan", {31'd0, busy}, 1);
    wait_result(b, "rst", 0);
    b = '0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++) b = set_cell(b, r, c, (((r + 2*c) / 2) % 2 == 1) ? 2 : 1);
    drive_and_check(b, "draw");
    @(negedge clk);
    b = set_cell('0, 2, 3, 2);
    grid = {14'd0, b};
    cur = b;
    @(posedge clk); #1;
    check("chg.busy", {31'd0, busy}, 1);
    repeat (49) @(posedge clk);
    @(negedge clk);
    b2 = b;
    for (int c = 0; c < 3; c++) b2 = set_cell(b2, 2, c, 2);
    grid = {14'd0, b2};
    cur = b2;
    wait_result(b, "chg1", 49);
    check("chg.idle", {31'd0, busy}, 0);
    @(posedge clk); #1;
    check("chg.rebusy", {31'd0, busy}, 1);
    check("chg.pulse", {31'd0, win_valid}, 0);
    wait_result(b2, "chg2", 0);
    for (int t = 0; t < 24; t++) begin
      b = '0;
      for (int r = 0; r < 6; r++)
        for (int c = 0; c < 7; c++) begin
          v = $urandom_range(0, 9);
          if (t % 3 == 0) b = set_cell(b, r, c, v == 8 ? 1 : v == 9 ? 2 : v == 7 ? 3 : 0);
          else b = set_cell(b, r, c, v < 3 ? 0 : v == 3 ? 3 : v < 7 ? 1 : 2);
        end
      if (b == cur) b[0] = ~b[0];
      drive_and_check(b, "rand");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
